// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 single-wire reader.
// Frame layout is B4..B0, B4 first on the wire.
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    REL,
    RESP_L,
    RESP_H,
    BIT_L,
    BIT_H,
    CHECK
  } state_e;

  localparam int START_LOW_US_DEF  = 18000;
  localparam int TIMEOUT_US_DEF    = 100;
  localparam int BIT_THRESH_US_DEF = 40;
  localparam int FRAME_BITS        = 40;

  function automatic logic sum_ok(
    input logic [39:0] f
  );
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return s == f[7:0];
  endfunction

endpackage

// File: rtl/dht11_reader_if.sv
// Sensor pins and result bundle of the DHT11 reader.
// master = reader side, slave = sensor/consumer side.
interface dht11_reader_if;

  logic       flag_five_sec;
  logic       dht_in;
  logic       dht_oe;
  logic [7:0] humidity;
  logic [7:0] temperature;
  logic       data_valid;
  logic       checksum_err;
  logic       timeout_err;
  logic       busy;

  modport master (
    input  flag_five_sec,
    input  dht_in,
    output dht_oe,
    output humidity,
    output temperature,
    output data_valid,
    output checksum_err,
    output timeout_err,
    output busy
  );

  modport slave (
    output flag_five_sec,
    output dht_in,
    input  dht_oe,
    input  humidity,
    input  temperature,
    input  data_valid,
    input  checksum_err,
    input  timeout_err,
    input  busy
  );

endinterface

// File: rtl/dht_sync.sv
// Two-flop synchronizer for the DATA line with edge outputs.
// Flops reset high to match the idle pulled-up line.
module dht_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/dht11_reader.sv
// Periodic DHT11 reader: start pulse, response, 40 bits, checksum.
// One clock cycle is one microsecond.
module dht11_reader
  import dht11_pkg::*;
#(
  parameter int START_LOW_US  = START_LOW_US_DEF,
  parameter int TIMEOUT_US    = TIMEOUT_US_DEF,
  parameter int BIT_THRESH_US = BIT_THRESH_US_DEF
) (
  input  logic       clk1M,
  input  logic       rst,
  input  logic       flag_five_sec,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic [7:0] humidity,
  output logic [7:0] temperature,
  output logic       data_valid,
  output logic       checksum_err,
  output logic       timeout_err,
  output logic       busy
);

  localparam logic [14:0] START_END = 15'(START_LOW_US - 1);
  localparam logic [14:0] TOUT      = 15'(TIMEOUT_US);
  localparam logic [14:0] THRESH    = 15'(BIT_THRESH_US);
  localparam logic [5:0]  LAST_BIT  = 6'(FRAME_BITS - 1);

  state_e      state_q;
  state_e      state_d;
  logic [14:0] timer_q;
  logic [5:0]  cnt_q;
  logic [39:0] shift_q;
  logic        flag_prev_q;
  logic        oe_q;
  logic        busy_q;
  logic [7:0]  hum_q;
  logic [7:0]  temp_q;
  logic        dv_q;
  logic        ce_q;
  logic        te_q;

  logic line;
  logic rise;
  logic fall;
  logic trig;
  logic tout;
  logic waiting;

  dht_sync u_sync (
    .clk_i  (clk1M),
    .rst_i  (rst),
    .d_i    (dht_in),
    .q_o    (line),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign trig    = flag_five_sec & ~flag_prev_q;
  assign waiting = state_q inside {REL, RESP_L, RESP_H, BIT_L, BIT_H};

  always_comb begin
    state_d = state_q;
    tout    = 1'b0;
    unique case (state_q)
      IDLE:    if (trig) state_d = START;
      START:   if (timer_q == START_END) state_d = REL;
      REL:     if (!line) state_d = RESP_L;
      RESP_L:  if (rise) state_d = RESP_H;
      RESP_H:  if (fall) state_d = BIT_L;
      BIT_L:   if (rise) state_d = BIT_H;
      BIT_H:   if (fall) state_d = (cnt_q == LAST_BIT) ? CHECK : BIT_L;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // An edge seen in the same cycle as the limit still wins.
    if (waiting && state_d == state_q && timer_q == TOUT) begin
      tout    = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk1M) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      flag_prev_q <= 1'b1;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      hum_q       <= '0;
      temp_q      <= '0;
      dv_q        <= 1'b0;
      ce_q        <= 1'b0;
      te_q        <= 1'b0;
    end else begin
      flag_prev_q <= flag_five_sec;
      state_q     <= state_d;
      timer_q     <= (state_d != state_q || state_d == IDLE)
                     ? '0 : timer_q + 15'd1;
      oe_q        <= state_d == START;
      busy_q      <= state_d != IDLE;
      dv_q        <= 1'b0;
      ce_q        <= 1'b0;
      te_q        <= tout;
      if (state_q == RESP_H) cnt_q <= '0;
      if (state_q == BIT_H && fall) begin
        shift_q <= {shift_q[38:0], timer_q > THRESH};
        cnt_q   <= cnt_q + 6'd1;
      end
      if (state_q == CHECK) begin
        if (sum_ok(shift_q)) begin
          hum_q  <= shift_q[39:32];
          temp_q <= shift_q[23:16];
          dv_q   <= 1'b1;
        end else begin
          ce_q <= 1'b1;
        end
      end
    end
  end

  assign dht_oe       = oe_q;
  assign busy         = busy_q;
  assign humidity     = hum_q;
  assign temperature  = temp_q;
  assign data_valid   = dv_q;
  assign checksum_err = ce_q;
  assign timeout_err  = te_q;

endmodule
